// File: rtl/uart_prom_loader_if.sv
// Byte stream from the UART receiver into the PROM loader.
// The master drives the byte and its valid flag; the slave answers with ready.
interface uart_prom_loader_if;
   logic [7:0] rx_data_i;
   logic       rx_valid_i;
   logic       rx_ready_o;

   modport master (output rx_data_i, output rx_valid_i, input rx_ready_o);
   modport slave  (input rx_data_i, input rx_valid_i, output rx_ready_o);
endinterface

// File: rtl/uart_prom_loader.sv
// Framed program loader: SYNC, N, N*WORD_BYTES data bytes, checksum C.
// Each assembled little-endian word is written to the PROM one cycle after its last byte.
module uart_prom_loader #(
   parameter int         WORD_BYTES = 2,
   parameter int         ROM_WORDS  = 64,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         enable_i,
   uart_prom_loader_if.slave            rx,
   output logic [$clog2(ROM_WORDS)-1:0] mem_addr_o,
   output logic [8*WORD_BYTES-1:0]      mem_data_o,
   output logic                         mem_we_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         error_o,
   output logic [7:0]                   words_written_o
);

   localparam int AW = $clog2(ROM_WORDS);
   localparam int DW = 8 * WORD_BYTES;
   localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

   localparam logic [2:0] ST_SYNC  = 3'd0;
   localparam logic [2:0] ST_LEN   = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_CSUM  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;
   localparam logic [2:0] ST_ERROR = 3'd6;

   if (WORD_BYTES < 1 || WORD_BYTES > 4) begin : g_bad_word_bytes
      $error("uart_prom_loader: WORD_BYTES must be 1..4");
   end
   if (ROM_WORDS < 2 || (ROM_WORDS & (ROM_WORDS - 1)) != 0) begin : g_bad_rom_words
      $error("uart_prom_loader: ROM_WORDS must be a power of 2 and at least 2");
   end

   logic [2:0]    state_q, state_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    sum_q, sum_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [DW-1:0] word_q, word_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    count_q, count_d;

   logic                  rx_ready;
   logic                  take;
   logic [7:0]            sum_plus;
   logic [7:0]            count_inc;
   logic [WORD_BYTES-1:0] lane_sel;

   genvar gi;
   generate
      for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
         assign lane_sel[gi] = (byte_idx_q == 2'(gi));
      end
   endgenerate

   assign rx_ready  = enable_i && (state_q != ST_WRITE);
   assign take      = rx.rx_valid_i && rx_ready;
   assign sum_plus  = sum_q + rx.rx_data_i;
   assign count_inc = count_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      sum_d      = sum_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      addr_d     = addr_q;
      count_d    = count_q;
      if (!enable_i) begin
         state_d    = ST_SYNC;
         len_d      = '0;
         sum_d      = '0;
         byte_idx_d = '0;
         word_d     = '0;
         addr_d     = '0;
         count_d    = '0;
      end else begin
         case (state_q)
            ST_SYNC: begin
               if (take && rx.rx_data_i == SYNC_BYTE) begin
                  sum_d      = '0;
                  byte_idx_d = '0;
                  word_d     = '0;
                  addr_d     = '0;
                  count_d    = '0;
                  state_d    = ST_LEN;
               end
            end
            ST_LEN: begin
               if (take) begin
                  len_d   = rx.rx_data_i;
                  sum_d   = sum_plus;
                  state_d = (rx.rx_data_i == 8'd0) ? ST_CSUM : ST_DATA;
               end
            end
            ST_DATA: begin
               if (take) begin
                  for (int k = 0; k < WORD_BYTES; k++) begin
                     if (lane_sel[k]) word_d[8*k +: 8] = rx.rx_data_i;
                  end
                  sum_d = sum_plus;
                  if (byte_idx_q == LAST_IDX) begin
                     byte_idx_d = '0;
                     state_d    = ST_WRITE;
                  end else begin
                     byte_idx_d = byte_idx_q + 2'd1;
                  end
               end
            end
            ST_WRITE: begin
               // Address wraps naturally because ROM_WORDS is a power of two.
               addr_d  = addr_q + 1'b1;
               count_d = count_inc;
               word_d  = '0;
               state_d = (count_inc == len_q) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
               if (take) state_d = (sum_plus == 8'd0) ? ST_DONE : ST_ERROR;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_SYNC;
         len_q      <= '0;
         sum_q      <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         addr_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         sum_q      <= sum_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
      end
   end

   assign rx.rx_ready_o     = rx_ready;
   assign mem_addr_o        = addr_q;
   assign mem_data_o        = word_q;
   assign mem_we_o          = enable_i && (state_q == ST_WRITE);
   assign busy_o            = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                              (state_q == ST_WRITE) || (state_q == ST_CSUM);
   assign done_o            = (state_q == ST_DONE);
   assign error_o           = (state_q == ST_ERROR);
   assign words_written_o   = count_q;

endmodule
